mem_port_arbiter: RTL and testbench

- Shares the single MMU core port (addr / wr_ena / wr_data / rd_data) between two requesters of the pipelined rv32i core: the instruction-fetch stage (read-only) and the data-memory stage (read/write).
- Each cycle the block grants at most one request. Read data returns one cycle later, steered to the owning requester.
- Data has priority over fetch. A starvation counter forces one fetch grant after a bounded run of data grants.
- Sits between the core and the MMU in rv32i_system.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_port_arbiter.sv | 111 +++++++++++
 tb/tb_mem_port_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the core-side memory port arbiter: response ownership
// and the word-alignment check applied to every granted address.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE,
        OWNER_I,
        OWNER_D
    } owner_t;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single MMU core port between instruction fetch and data memory.
// Data wins by default; a starvation counter forces one fetch grant after a bounded wait.
//
//   state       | meaning
//   OWNER_NONE  | no read response due this cycle
//   OWNER_I     | fetch read granted last cycle, data returns to fetch now
//   OWNER_D     | data read granted last cycle, data returns to data stage now
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_STARVE = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err_misaligned,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_ena,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data
);

    logic [3:0]        starve_cnt;
    owner_t            resp_owner;
    logic              resp_zero;
    logic [ADDR_W-1:0] last_addr;
    logic              force_i;
    logic              gnt_misaligned;

    always_comb begin
        force_i = (starve_cnt == 4'(MAX_STARVE));
        d_gnt   = 1'b0;
        i_gnt   = 1'b0;
        if (!rst && ena) begin
            if (d_req && !(force_i && i_req)) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_misaligned = 1'b0;
        mem_addr       = last_addr;
        mem_wr_data    = '0;
        if (rst) begin
            mem_addr = '0;
        end else if (d_gnt) begin
            gnt_misaligned = is_misaligned(d_addr[1:0]);
            mem_addr       = d_addr;
            mem_wr_data    = d_wdata;
        end else if (i_gnt) begin
            gnt_misaligned = is_misaligned(i_addr[1:0]);
            mem_addr       = i_addr;
        end
    end

    // A misaligned write is consumed but must never reach the MMU.
    assign mem_wr_ena = d_gnt && d_we && !gnt_misaligned;

    assign i_rvalid = (resp_owner == OWNER_I);
    assign d_rvalid = (resp_owner == OWNER_D);
    assign i_rdata  = (i_rvalid && !resp_zero) ? mem_rd_data : '0;
    assign d_rdata  = (d_rvalid && !resp_zero) ? mem_rd_data : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_owner     <= OWNER_NONE;
            resp_zero      <= 1'b0;
            err_misaligned <= 1'b0;
            last_addr      <= '0;
            starve_cnt     <= '0;
        end else begin
            if (i_gnt) begin
                resp_owner <= OWNER_I;
            end else if (d_gnt && !d_we) begin
                resp_owner <= OWNER_D;
            end else begin
                resp_owner <= OWNER_NONE;
            end
            resp_zero      <= gnt_misaligned;
            err_misaligned <= gnt_misaligned;
            if (i_gnt || d_gnt) begin
                last_addr <= mem_addr;
            end
            if (ena) begin
                if (!i_req || i_gnt) begin
                    starve_cnt <= '0;
                end else if (starve_cnt != 4'(MAX_STARVE)) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a behavioural
// model of grant priority, fetch waiting time and one-cycle read returns.
module tb_mem_port_arbiter;

    localparam int MAX_STARVE = 4;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              ena;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              err_misaligned;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr_ena;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;

    int checks = 0;
    int errors = 0;

    // Model state: how long fetch has waited, which requester a read is due to.
    int                m_waited;
    int                m_pend;      // 0 none, 1 fetch, 2 data
    logic              m_pend_zero;
    logic              m_err;
    logic [ADDR_W-1:0] m_last_addr;

    mem_port_arbiter #(
        .MAX_STARVE(MAX_STARVE),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ena           (ena),
        .i_req         (i_req),
        .i_addr        (i_addr),
        .i_gnt         (i_gnt),
        .i_rvalid      (i_rvalid),
        .i_rdata       (i_rdata),
        .d_req         (d_req),
        .d_we          (d_we),
        .d_addr        (d_addr),
        .d_wdata       (d_wdata),
        .d_gnt         (d_gnt),
        .d_rvalid      (d_rvalid),
        .d_rdata       (d_rdata),
        .err_misaligned(err_misaligned),
        .mem_addr      (mem_addr),
        .mem_wr_ena    (mem_wr_ena),
        .mem_wr_data   (mem_wr_data),
        .mem_rd_data   (mem_rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_waited    = 0;
        m_pend      = 0;
        m_pend_zero = 1'b0;
        m_err       = 1'b0;
        m_last_addr = '0;
    endtask

    // Compare every output against the model mid-cycle, then advance the model
    // to what the coming rising edge must produce.
    task automatic tick();
        logic e_d, e_i, forced, mis;
        logic [ADDR_W-1:0] e_addr;
        #2;
        forced = (m_waited >= MAX_STARVE) && i_req;
        e_d    = ena && d_req && !forced;
        e_i    = ena && i_req && !e_d;
        e_addr = e_d ? d_addr : (e_i ? i_addr : m_last_addr);
        mis    = e_d ? (d_addr[1:0] != 2'b00) : (e_i ? (i_addr[1:0] != 2'b00) : 1'b0);
        chk("d_gnt", 32'(d_gnt), 32'(e_d));
        chk("i_gnt", 32'(i_gnt), 32'(e_i));
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wr_ena", 32'(mem_wr_ena), 32'(e_d && d_we && !mis));
        if (e_d && d_we && !mis) chk("mem_wr_data", mem_wr_data, d_wdata);
        chk("i_rvalid", 32'(i_rvalid), 32'(m_pend == 1));
        chk("d_rvalid", 32'(d_rvalid), 32'(m_pend == 2));
        if (m_pend == 1) chk("i_rdata", i_rdata, m_pend_zero ? 32'h0 : mem_rd_data);
        if (m_pend == 2) chk("d_rdata", d_rdata, m_pend_zero ? 32'h0 : mem_rd_data);
        chk("err_misaligned", 32'(err_misaligned), 32'(m_err));

        m_pend      = e_i ? 1 : ((e_d && !d_we) ? 2 : 0);
        m_pend_zero = mis;
        m_err       = mis;
        if (e_d || e_i) m_last_addr = e_addr;
        if (ena) begin
            if (!i_req || e_i) m_waited = 0;
            else if (m_waited < 100) m_waited++;
        end
    endtask

    task automatic idle_inputs();
        ena     = 1'b1;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
    endtask

    initial begin
        rst         = 1'b1;
        mem_rd_data = '0;
        idle_inputs();
        model_reset();
        i_req = 1'b1;
        d_req = 1'b1;
        @(negedge clk);
        #2;
        chk("rst_i_gnt", 32'(i_gnt), 32'h0);
        chk("rst_d_gnt", 32'(d_gnt), 32'h0);
        chk("rst_i_rvalid", 32'(i_rvalid), 32'h0);
        chk("rst_d_rvalid", 32'(d_rvalid), 32'h0);
        chk("rst_err", 32'(err_misaligned), 32'h0);
        chk("rst_mem_wr_ena", 32'(mem_wr_ena), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();

        // Fetch only
        i_req = 1'b1; i_addr = 32'h4; mem_rd_data = 32'h0050_0093;
        tick();
        chk("fetch_gnt", 32'(i_gnt), 32'h1);
        @(negedge clk);
        i_req = 1'b0;
        tick();
        chk("fetch_rvalid", 32'(i_rvalid), 32'h1);
        chk("fetch_rdata", i_rdata, 32'h0050_0093);
        chk("fetch_no_drvalid", 32'(d_rvalid), 32'h0);
        @(negedge clk);

        // Simultaneous requests: data wins
        d_req = 1'b1; d_addr = 32'h100; i_req = 1'b1; i_addr = 32'h8;
        tick();
        chk("sim_d_gnt", 32'(d_gnt), 32'h1);
        chk("sim_i_gnt", 32'(i_gnt), 32'h0);
        chk("sim_addr", mem_addr, 32'h100);
        @(negedge clk);
        d_req = 1'b0; i_req = 1'b0;
        tick();
        chk("sim_d_rvalid", 32'(d_rvalid), 32'h1);
        chk("sim_i_rvalid", 32'(i_rvalid), 32'h0);
        @(negedge clk);

        // Starvation: four data grants, one forced fetch, then data again
        d_req = 1'b1; d_addr = 32'h100; i_req = 1'b1; i_addr = 32'h8;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("starve_i_gnt", 32'(i_gnt), (k == 4) ? 32'h1 : 32'h0);
            chk("starve_d_gnt", 32'(d_gnt), (k == 4) ? 32'h0 : 32'h1);
            @(negedge clk);
        end

        // Write
        i_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
        tick();
        chk("wr_ena", 32'(mem_wr_ena), 32'h1);
        chk("wr_data", mem_wr_data, 32'hDEAD_BEEF);
        @(negedge clk);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        chk("wr_no_rvalid", 32'(d_rvalid), 32'h0);
        @(negedge clk);

        // Misaligned data read
        d_req = 1'b1; d_addr = 32'h102;
        tick();
        chk("mis_gnt", 32'(d_gnt), 32'h1);
        chk("mis_wr_ena", 32'(mem_wr_ena), 32'h0);
        @(negedge clk);
        d_req = 1'b0; mem_rd_data = 32'h1234_5678;
        tick();
        chk("mis_err", 32'(err_misaligned), 32'h1);
        chk("mis_rvalid", 32'(d_rvalid), 32'h1);
        chk("mis_rdata", d_rdata, 32'h0);
        @(negedge clk);

        // Enable low: no grants
        ena = 1'b0; i_req = 1'b1; d_req = 1'b1; d_addr = 32'h300; i_addr = 32'h30;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ena0_gnt", 32'({i_gnt, d_gnt}), 32'h0);
            @(negedge clk);
        end
        idle_inputs();

        // Reset while a fetch response is in flight
        i_req = 1'b1; i_addr = 32'h40;
        tick();
        chk("rst_pre_gnt", 32'(i_gnt), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_gnt", 32'(i_gnt), 32'h0);
        @(negedge clk);
        chk("rst_drop_i_rvalid", 32'(i_rvalid), 32'h0);
        chk("rst_drop_d_rvalid", 32'(d_rvalid), 32'h0);
        rst = 1'b0;
        model_reset();
        idle_inputs();
        tick();
        @(negedge clk);
        d_req = 1'b1; i_req = 1'b1; d_addr = 32'h500; i_addr = 32'h50;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("post_rst_i_gnt", 32'(i_gnt), (k == 4) ? 32'h1 : 32'h0);
            @(negedge clk);
        end

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            ena         = ($urandom_range(0, 9) != 0);
            i_req       = ($urandom_range(0, 3) != 0);
            d_req       = ($urandom_range(0, 2) != 0);
            d_we        = $urandom_range(0, 1) == 1;
            i_addr      = {$urandom_range(0, 32'hFFFF), 2'b00};
            d_addr      = {$urandom_range(0, 32'hFFFF), 2'b00};
            if ($urandom_range(0, 7) == 0) i_addr[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) d_addr[1:0] = 2'($urandom_range(1, 3));
            d_wdata     = $urandom;
            mem_rd_data = $urandom;
            tick();
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
